// File: rtl/stage_skid_reg_pkg.sv
// Shared definitions for the pipeline-stage skid register: state encoding,
// default payload width and a small decode helper.
package stage_skid_reg_pkg;

  // Default payload width used by the CPU pipeline stages.
  localparam int unsigned StageDataW = 64;

  // Width of the pc and instruction fields carried with each entry.
  localparam int unsigned StagePcW = 32;

  // Number of held entries is encoded directly in the state value.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } stage_state_e;

  // Map a state to its entry count; the unused encoding reports zero.
  function automatic logic [1:0] state_occupancy(input stage_state_e st);
    logic [1:0] occ;
    occ = 2'd0;
    case (st)
      StEmpty: occ = 2'd0;
      StOne:   occ = 2'd1;
      StFull:  occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/stage_entry_reg.sv
// One pipeline entry {pc, instr, payload, we} with load and clear controls.
// Clear has priority over load.
module stage_entry_reg
  import stage_skid_reg_pkg::*;
#(
  parameter int unsigned DATA_W = StageDataW
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_load,
  input  logic                  i_clear,
  input  logic [StagePcW-1:0]   i_pc,
  input  logic [StagePcW-1:0]   i_instr,
  input  logic [DATA_W-1:0]     i_payload,
  input  logic                  i_we,
  output logic [StagePcW-1:0]   o_pc,
  output logic [StagePcW-1:0]   o_instr,
  output logic [DATA_W-1:0]     o_payload,
  output logic                  o_we
);

  logic [StagePcW-1:0] r_pc;
  logic [StagePcW-1:0] r_instr;
  logic [DATA_W-1:0]   r_payload;
  logic                r_we;

  // Entry storage: async reset to zero, then clear, then load.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc      <= '0;
      r_instr   <= '0;
      r_payload <= '0;
      r_we      <= 1'b0;
    end else if (i_clear) begin
      r_pc      <= '0;
      r_instr   <= '0;
      r_payload <= '0;
      r_we      <= 1'b0;
    end else if (i_load) begin
      r_pc      <= i_pc;
      r_instr   <= i_instr;
      r_payload <= i_payload;
      r_we      <= i_we;
    end
  end

  assign o_pc      = r_pc;
  assign o_instr   = r_instr;
  assign o_payload = r_payload;
  assign o_we      = r_we;

endmodule

// File: rtl/stage_skid_reg.sv
// Two-entry skid register between pipeline stages. The head (main) entry
// always drives out_*; the skid entry absorbs one extra entry so that
// in_ready can be decoded from state alone, with no path from out_ready.
module stage_skid_reg
  import stage_skid_reg_pkg::*;
#(
  parameter int unsigned DATA_W         = StageDataW,
  parameter bit          CLEAR_ON_FLUSH = 1'b1,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_pc,
  input  logic [31:0]         in_instr,
  input  logic [DATA_W-1:0]   in_payload,
  input  logic                in_we,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_pc,
  output logic [31:0]         out_instr,
  output logic [DATA_W-1:0]   out_payload,
  output logic                out_we,
  output logic [1:0]          occupancy,
  output logic [CNT_W-1:0]    stall_cnt,
  input  logic                clr_stall
);

  stage_state_e r_state;
  stage_state_e w_state_d;

  logic w_in_fire;
  logic w_out_fire;
  logic w_main_load;
  logic w_skid_load;
  logic w_main_from_skid;
  logic w_clear;

  // Main entry outputs.
  logic [31:0]       w_main_pc;
  logic [31:0]       w_main_instr;
  logic [DATA_W-1:0] w_main_payload;
  logic              w_main_we;

  // Skid entry outputs.
  logic [31:0]       w_skid_pc;
  logic [31:0]       w_skid_instr;
  logic [DATA_W-1:0] w_skid_payload;
  logic              w_skid_we;

  // Main entry next value: either the incoming entry or the skid entry.
  logic [31:0]       w_main_d_pc;
  logic [31:0]       w_main_d_instr;
  logic [DATA_W-1:0] w_main_d_payload;
  logic              w_main_d_we;

  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] w_stall_cnt_d;

  // Handshake decode; ready and valid depend on state only.
  always_comb begin
    in_ready   = (r_state != StFull);
    out_valid  = (r_state != StEmpty);
    w_in_fire  = in_valid & in_ready;
    w_out_fire = out_valid & out_ready;
    w_clear    = flush & CLEAR_ON_FLUSH;
  end

  // Next-state and entry load controls; flush overrides every transfer.
  always_comb begin
    w_state_d        = r_state;
    w_main_load      = 1'b0;
    w_skid_load      = 1'b0;
    w_main_from_skid = 1'b0;
    if (flush) begin
      w_state_d = StEmpty;
    end else begin
      case (r_state)
        StEmpty: begin
          if (w_in_fire) begin
            w_main_load = 1'b1;
            w_state_d   = StOne;
          end
        end
        StOne: begin
          if (w_in_fire && w_out_fire) begin
            w_main_load = 1'b1;
          end else if (w_in_fire) begin
            w_skid_load = 1'b1;
            w_state_d   = StFull;
          end else if (w_out_fire) begin
            w_state_d = StEmpty;
          end
        end
        StFull: begin
          if (w_out_fire) begin
            w_main_load      = 1'b1;
            w_main_from_skid = 1'b1;
            w_state_d        = StOne;
          end
        end
        default: begin
          // Unused encoding: recover to empty on the next edge.
          w_state_d = StEmpty;
        end
      endcase
    end
  end

  // Select the source for the main entry.
  always_comb begin
    if (w_main_from_skid) begin
      w_main_d_pc      = w_skid_pc;
      w_main_d_instr   = w_skid_instr;
      w_main_d_payload = w_skid_payload;
      w_main_d_we      = w_skid_we;
    end else begin
      w_main_d_pc      = in_pc;
      w_main_d_instr   = in_instr;
      w_main_d_payload = in_payload;
      w_main_d_we      = in_we;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StEmpty;
    end else begin
      r_state <= w_state_d;
    end
  end

  stage_entry_reg #(
    .DATA_W (DATA_W)
  ) u_main (
    .i_clk     (clk),
    .i_rst_n   (reset),
    .i_load    (w_main_load),
    .i_clear   (w_clear),
    .i_pc      (w_main_d_pc),
    .i_instr   (w_main_d_instr),
    .i_payload (w_main_d_payload),
    .i_we      (w_main_d_we),
    .o_pc      (w_main_pc),
    .o_instr   (w_main_instr),
    .o_payload (w_main_payload),
    .o_we      (w_main_we)
  );

  stage_entry_reg #(
    .DATA_W (DATA_W)
  ) u_skid (
    .i_clk     (clk),
    .i_rst_n   (reset),
    .i_load    (w_skid_load),
    .i_clear   (w_clear),
    .i_pc      (in_pc),
    .i_instr   (in_instr),
    .i_payload (in_payload),
    .i_we      (in_we),
    .o_pc      (w_skid_pc),
    .o_instr   (w_skid_instr),
    .o_payload (w_skid_payload),
    .o_we      (w_skid_we)
  );

  // Stall counter next value: clear wins, otherwise saturating increment.
  always_comb begin
    w_stall_cnt_d = r_stall_cnt;
    if (clr_stall) begin
      w_stall_cnt_d = '0;
    end else if (out_valid && !out_ready && !flush && (r_stall_cnt != {CNT_W{1'b1}})) begin
      w_stall_cnt_d = r_stall_cnt + 1'b1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
    end else begin
      r_stall_cnt <= w_stall_cnt_d;
    end
  end

  // Head entry outputs; write enable is masked so a bubble never writes.
  always_comb begin
    out_pc      = w_main_pc;
    out_instr   = w_main_instr;
    out_payload = w_main_payload;
    out_we      = w_main_we & out_valid;
    occupancy   = state_occupancy(r_state);
    stall_cnt   = r_stall_cnt;
  end

endmodule

// File: tb/tb_stage_skid_reg.sv
// Directed bench for stage_skid_reg with a queue-based scoreboard.
module tb_stage_skid_reg;

  localparam int unsigned DW = 64;
  localparam int unsigned CW = 4;

  typedef struct packed {
    logic [31:0]   pc;
    logic [31:0]   instr;
    logic [DW-1:0] payload;
    logic          we;
  } ent_t;

  logic          clk;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_pc;
  logic [31:0]   in_instr;
  logic [DW-1:0] in_payload;
  logic          in_we;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_pc;
  logic [31:0]   out_instr;
  logic [DW-1:0] out_payload;
  logic          out_we;
  logic [1:0]    occupancy;
  logic [CW-1:0] stall_cnt;
  logic          clr_stall;

  int   n_cmp;
  int   n_err;
  ent_t q[$];
  int   m_stall;

  stage_skid_reg #(
    .DATA_W         (DW),
    .CLEAR_ON_FLUSH (1'b1),
    .CNT_W          (CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_pc       (in_pc),
    .in_instr    (in_instr),
    .in_payload  (in_payload),
    .in_we       (in_we),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_instr   (out_instr),
    .out_payload (out_payload),
    .out_we      (out_we),
    .occupancy   (occupancy),
    .stall_cnt   (stall_cnt),
    .clr_stall   (clr_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] pc, input logic we);
    in_valid   = 1'b1;
    in_pc      = pc;
    in_instr   = pc ^ 32'hA5A5_0013;
    in_payload = {$urandom, $urandom};
    in_we      = we;
  endtask

  task automatic idle_in();
    in_valid   = 1'b0;
    in_pc      = 32'hDEAD_BEEF;
    in_instr   = 32'h0;
    in_payload = '0;
    in_we      = 1'b1;
  endtask

  // Check outputs against the scoreboard, advance the model, then clock once.
  task automatic cycle();
    int   occ;
    logic infire;
    logic outfire;
    ent_t e;
    occ = q.size();
    chk("in_ready", 64'(in_ready), 64'(occ != 2));
    chk("out_valid", 64'(out_valid), 64'(occ != 0));
    chk("occupancy", 64'(occupancy), 64'(occ));
    chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
    if (occ != 0) begin
      chk("out_pc", 64'(out_pc), 64'(q[0].pc));
      chk("out_instr", 64'(out_instr), 64'(q[0].instr));
      chk("out_payload", out_payload, q[0].payload);
      chk("out_we", 64'(out_we), 64'(q[0].we));
    end else begin
      chk("out_we_bubble", 64'(out_we), 64'(0));
    end
    infire  = in_valid && (occ != 2);
    outfire = (occ != 0) && out_ready;
    if (clr_stall) m_stall = 0;
    else if ((occ != 0) && !out_ready && !flush && m_stall != 15) m_stall++;
    if (flush) begin
      q.delete();
    end else begin
      if (outfire) void'(q.pop_front());
      if (infire) begin
        e.pc = in_pc; e.instr = in_instr; e.payload = in_payload; e.we = in_we;
        q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0; n_err = 0; m_stall = 0;
    reset = 1'b0; flush = 1'b0; out_ready = 1'b0; clr_stall = 1'b0;
    drive(32'h1111_0000, 1'b1);
    #2;
    // Reset state, and no capture while reset is held across an edge.
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_occupancy", 64'(occupancy), 64'(0));
    chk("rst_out_we", 64'(out_we), 64'(0));
    chk("rst_stall", 64'(stall_cnt), 64'(0));
    @(posedge clk); #1;
    chk("rst_no_capture", 64'(occupancy), 64'(0));
    chk("rst_out_pc", 64'(out_pc), 64'(0));
    reset = 1'b1;
    idle_in();
    cycle();

    // Streaming with out_ready high: one-cycle latency, occupancy stays 1.
    out_ready = 1'b1;
    drive(32'h3000, 1'b1); cycle();
    chk("stream_pc0", 64'(out_pc), 64'h3000);
    drive(32'h3004, 1'b0); cycle();
    chk("stream_pc1", 64'(out_pc), 64'h3004);
    chk("stream_occ", 64'(occupancy), 64'(1));
    drive(32'h3008, 1'b1); cycle();
    chk("stream_pc2", 64'(out_pc), 64'h3008);
    idle_in(); cycle();
    cycle();

    // Backpressure: two entries held, two stall cycles, then drain in order.
    out_ready = 1'b0;
    drive(32'h3000, 1'b1); cycle();
    drive(32'h3004, 1'b0); cycle();
    idle_in(); cycle();
    chk("bp_occ", 64'(occupancy), 64'(2));
    chk("bp_in_ready", 64'(in_ready), 64'(0));
    chk("bp_stall", 64'(stall_cnt), 64'(2));
    drive(32'h3010, 1'b1); cycle();   // refused while full
    idle_in();
    out_ready = 1'b1;
    cycle();
    chk("bp_drain0", 64'(out_pc), 64'h3004);
    cycle();
    cycle();
    clr_stall = 1'b1; cycle(); clr_stall = 1'b0;

    // Flush while full: contents zeroed, write enable never escapes.
    out_ready = 1'b0;
    drive(32'h4000, 1'b1); cycle();
    drive(32'h4004, 1'b1); cycle();
    flush = 1'b1; drive(32'h4008, 1'b1); cycle();
    flush = 1'b0; idle_in();
    chk("flush_occ", 64'(occupancy), 64'(0));
    chk("flush_valid", 64'(out_valid), 64'(0));
    chk("flush_we", 64'(out_we), 64'(0));
    chk("flush_pc", 64'(out_pc), 64'(0));
    for (int i = 0; i < 3; i++) cycle();

    // Flush in ONE with a simultaneous consume.
    out_ready = 1'b1;
    drive(32'h4100, 1'b1); cycle();
    idle_in(); flush = 1'b1; cycle(); flush = 1'b0;
    cycle();

    // Stall counter saturation and clear priority.
    clr_stall = 1'b1; cycle(); clr_stall = 1'b0;
    out_ready = 1'b0;
    drive(32'h5000, 1'b0); cycle();
    idle_in();
    for (int i = 0; i < 20; i++) cycle();
    chk("sat_stall", 64'(stall_cnt), 64'(15));
    clr_stall = 1'b1; cycle(); clr_stall = 1'b0;
    chk("clr_stall", 64'(stall_cnt), 64'(0));
    out_ready = 1'b1; cycle(); cycle();

    // Asynchronous reset while full.
    out_ready = 1'b0;
    drive(32'h6000, 1'b1); cycle();
    drive(32'h6004, 1'b1); cycle();
    idle_in();
    chk("pre_arst_occ", 64'(occupancy), 64'(2));
    #2 reset = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'(0));
    chk("arst_occ", 64'(occupancy), 64'(0));
    chk("arst_we", 64'(out_we), 64'(0));
    chk("arst_stall", 64'(stall_cnt), 64'(0));
    chk("arst_in_ready", 64'(in_ready), 64'(1));
    q.delete(); m_stall = 0;
    @(posedge clk); #2;
    reset = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    drive(32'h7000, 1'b1); cycle();
    chk("post_arst_pc", 64'(out_pc), 64'h7000);
    idle_in(); cycle();
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/stage_skid_reg.md
STAGE_SKID_REG -- requirements
Module: stage_skid_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 64, meaning payload width in bits (range 1..256).
REQ-002 SHALL have parameter CLEAR_ON_FLUSH, default 1, meaning when 1 a flush zeroes the stored data registers; when 0 it only clears the valid bits.
REQ-003 SHALL have parameter CNT_W, default 16, meaning the width of the stall counter.
REQ-004 Port list (name, direction, width, meaning):
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous flush; discards every held entry.
- in_valid  in  1  the upstream stage presents an entry.
- in_ready  out  1  this block accepts an entry this cycle.
- in_pc  in  32  pc of the entry.
- in_instr  in  32  instruction word of the entry.
- in_payload  in  DATA_W  data of the entry (ALU result, memory data, ...).
- in_we  in  1  register-write enable of the entry.
- out_valid  out  1  the head entry is valid.
- out_ready  in  1  the downstream stage consumes the head entry.
- out_pc, out_instr  out  32 each  pc and instruction of the head entry.
- out_payload  out  DATA_W  payload of the head entry.
- out_we  out  1  write enable of the head entry, gated by out_valid.
- occupancy  out  2  number of held entries (0..2).
- stall_cnt  out  CNT_W  count of backpressure cycles.
- clr_stall  in  1  synchronous clear of stall_cnt.

Function
REQ-005 Storage SHALL be a main register (the head) plus a skid register, with a state machine of three states: EMPTY (0 entries), ONE (main only), FULL (main and skid).
REQ-006 Handshake terms: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
REQ-007 in_ready SHALL be 1 exactly when state != FULL, decoded from state only, with no combinational path from out_ready.
REQ-008 out_valid SHALL be 1 exactly when state != EMPTY; out_* SHALL always show the main register.
REQ-009 Transitions from EMPTY: in_fire loads main and goes to ONE.
REQ-010 Transitions from ONE:
- in_fire & !out_fire: load skid and go to FULL.
- out_fire & !in_fire: go to EMPTY.
- both: main <= input and stay in ONE.
REQ-011 Transitions from FULL: out_fire moves skid into main and goes to ONE; otherwise hold.
REQ-012 Latency: an entry accepted in cycle N SHALL appear on out_* in cycle N+1 when the block was EMPTY or out_fire occurred in cycle N.
REQ-013 Ordering: entries SHALL leave in acceptance order; none dropped, none duplicated.
REQ-014 flush SHALL take priority over in_fire and out_fire:
- next state EMPTY;
- if CLEAR_ON_FLUSH=1, main and skid data are zeroed;
- an out_fire in the flush cycle still counts as consumed.
REQ-015 out_we SHALL equal main_we & out_valid, so a bubble never writes.
REQ-016 occupancy SHALL be 0/1/2 for EMPTY/ONE/FULL.
REQ-017 stall_cnt:
- increments by 1 each cycle with out_valid & !out_ready & !flush;
- saturates at all-ones;
- clr_stall zeroes it and has priority over increment.
REQ-018 The encoding 2'b11 for occupancy or state SHALL be unreachable; if ever entered, the next edge goes to EMPTY.

Reset
REQ-019 While reset=0, state SHALL be EMPTY, all data registers and stall_cnt SHALL be 0, out_valid=0, out_we=0, occupancy=0, and in_ready=1.
REQ-020 No entry SHALL be captured while reset=0.
REQ-021 Reset asserted mid-operation SHALL discard held entries immediately, without waiting for a clock edge.

Structure
REQ-022 The state encoding (EMPTY=0, ONE=1, FULL=2) SHALL live in a shared package, together with the default DATA_W for the CPU pipeline stages.
REQ-023 A single sub-module, stage_entry_reg, SHALL hold one {pc, instr, payload, we} entry with load and clear controls; it is instantiated twice (main and skid).

Verification
REQ-024 Reset then stream: in_valid=1 with pc 0x3000, 0x3004, 0x3008 and out_ready=1 -> out_pc is 0x3000, 0x3004, 0x3008 on consecutive cycles starting one cycle after acceptance; occupancy stays 1.
REQ-025 Backpressure: out_ready=0 and push 0x3000 then 0x3004 -> occupancy=2, in_ready=0, stall_cnt=2 after two stalled cycles; raise out_ready -> 0x3000 then 0x3004 are delivered, with no loss.
REQ-026 Flush when FULL with CLEAR_ON_FLUSH=1 -> next cycle occupancy=0, out_valid=0, out_we=0, out_pc=0.
REQ-027 Entry with in_we=1 followed by flush -> out_we never pulses after the flush.
REQ-028 Saturation and clear: CNT_W=4 with 20 stalled cycles -> stall_cnt=15; clr_stall together with a stall -> 0.
REQ-029 Asynchronous reset: drive reset low between clock edges while FULL -> out_valid=0 immediately; after reset is released, the first accepted entry appears normally.
